// File: rtl/line_score_accumulator.sv
// Sums weighted per-pixel reductions for each candidate line in a sweep and reports
// the highest-scoring line (pin, score, length) with a one-cycle done pulse.
module line_score_accumulator #(
  parameter int RED_W = 16,
  parameter int ACC_W = 24,
  parameter int PIN_W = 9,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RED_W-1:0] in_reduction,
  input  logic [3:0]       in_weight,
  input  logic             in_last,
  input  logic [PIN_W-1:0] in_pin,
  input  logic             sweep_last,
  output logic             busy,
  output logic             done,
  output logic [PIN_W-1:0] best_pin,
  output logic [ACC_W-1:0] best_score,
  output logic [LEN_W-1:0] best_len,
  output logic             best_pos
);

  localparam int PROD_W = RED_W + 5;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [1:0]              state;
  logic [ACC_W-1:0]        line_sum;
  logic [LEN_W-1:0]        line_len;
  logic [PIN_W-1:0]        line_pin;
  logic                    line_sweep_last;

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W:0]           sum_wide;
  logic [ACC_W-1:0]         sum_sat;
  logic [LEN_W-1:0]         len_inc;
  logic                     transfer;
  logic                     take_line;
  logic [ACC_W-1:0]         next_best;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign transfer = in_valid & in_ready;

  // Both operands widened to the full product width so the signed multiply never truncates.
  assign prod     = PROD_W'($signed(in_reduction)) * PROD_W'($signed({1'b0, in_weight}));
  assign sum_wide = {line_sum[ACC_W-1], line_sum}
                  + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign len_inc   = (line_len == LEN_MAX) ? line_len : line_len + 1'b1;
  assign take_line = $signed(line_sum) > $signed(best_score);
  assign next_best = take_line ? line_sum : best_score;

  // NOTE: state is written with non-blocking assignments only; blocking here would create
  // read-after-write ordering races between the line registers and the best registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register is reset (there is no memory array), so an aborted sweep
      // cannot leak a partial line or stale best result into the next one.
      state           <= IDLE;
      line_sum        <= '0;
      line_len        <= '0;
      line_pin        <= '0;
      line_sweep_last <= 1'b0;
      best_pin        <= '0;
      best_score      <= ACC_MIN;
      best_len        <= '0;
      best_pos        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            line_sum   <= '0;
            line_len   <= '0;
            best_pin   <= '0;
            best_score <= ACC_MIN;
            best_len   <= '0;
            best_pos   <= 1'b0;
          end
        end

        ACCUM: begin
          if (transfer) begin
            line_sum <= sum_sat;
            line_len <= len_inc;
            if (in_last) begin
              line_pin        <= in_pin;
              line_sweep_last <= sweep_last;
              state           <= COMPARE;
            end
          end
        end

        COMPARE: begin
          // Strict compare: a tie keeps the earlier line.
          if (take_line) begin
            best_pin   <= line_pin;
            best_score <= line_sum;
            best_len   <= line_len;
          end
          line_sum <= '0;
          line_len <= '0;
          if (line_sweep_last) begin
            best_pos <= !next_best[ACC_W-1] && (next_best != '0);
            state    <= DONE;
          end else begin
            state <= ACCUM;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_score_accumulator.sv
// Self-checking bench for line_score_accumulator: directed scenarios plus random sweeps
// compared against a line-level arithmetic model of the scoring rules.
module tb_line_score_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_reduction;
  logic [3:0]  in_weight;
  logic        in_last;
  logic [8:0]  in_pin;
  logic        sweep_last;
  logic        busy;
  logic        done;
  logic [8:0]  best_pin;
  logic [23:0] best_score;
  logic [10:0] best_len;
  logic        best_pos;

  always #5 clk = ~clk;

  line_score_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reduction (in_reduction),
    .in_weight    (in_weight),
    .in_last      (in_last),
    .in_pin       (in_pin),
    .sweep_last   (sweep_last),
    .busy         (busy),
    .done         (done),
    .best_pin     (best_pin),
    .best_score   (best_score),
    .best_len     (best_len),
    .best_pos     (best_pos)
  );

  typedef struct {
    logic [15:0] red;
    logic [3:0]  wt;
    bit          last;
    logic [8:0]  pin;
    bit          sl;
  } beat_t;

  typedef struct {
    int                 latency;
    logic [8:0]         pin;
    logic signed [23:0] score;
    logic [10:0]        len;
    logic               pos;
    int                 compare_ready;
    bit                 pulse_ok;
    bit                 hold_ok;
    logic               busy_after;
  } obs_t;

  typedef struct {
    logic [8:0] pin;
    longint     score;
    int         len;
    bit         pos;
  } exp_t;

  beat_t sq[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic void add_line(input int pin, input bit sl, input int n, input int red,
                                   input int wt);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.red  = 16'(red);
      b.wt   = 4'(wt);
      b.last = (i == n - 1);
      b.pin  = 9'(pin);
      b.sl   = sl;
      sq.push_back(b);
    end
  endfunction

  // Line-level reference: saturating running sum per line, strict-greater best tracking.
  function automatic exp_t model();
    exp_t   e;
    longint cur = 0;
    longint r;
    longint w;
    int     n = 0;
    e.pin   = '0;
    e.score = -(longint'(1) <<< 23);
    e.len   = 0;
    foreach (sq[i]) begin
      r = $signed(sq[i].red);
      w = sq[i].wt;
      cur = cur + r * w;
      if (cur > 8388607)  cur = 8388607;
      if (cur < -8388608) cur = -8388608;
      n = (n < 2047) ? n + 1 : 2047;
      if (sq[i].last) begin
        if (cur > e.score) begin
          e.score = cur;
          e.pin   = sq[i].pin;
          e.len   = n;
        end
        cur = 0;
        n   = 0;
      end
    end
    e.pos = (e.score > 0);
    return e;
  endfunction

  // Presents one beat from a negedge and returns at the negedge after it was accepted.
  task automatic send_beat(input beat_t b, output bit ok);
    int budget = 20;
    in_valid     = 1'b1;
    in_reduction = b.red;
    in_weight    = b.wt;
    in_last      = b.last;
    in_pin       = b.pin;
    sweep_last   = b.sl;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_sweep(input int mid_start, input bit start_at_done, output obs_t o);
    bit ok;
    o.latency       = -1;
    o.pin           = '0;
    o.score         = '0;
    o.len           = '0;
    o.pos           = 1'b0;
    o.compare_ready = 0;
    o.pulse_ok      = 1'b0;
    o.hold_ok       = 1'b0;
    o.busy_after    = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (sq[i]) begin
      if (i == mid_start) start = 1'b1;
      send_beat(sq[i], ok);
      start = 1'b0;
      if (!ok) return;
      if (sq[i].last && i != sq.size() - 1 && in_ready) o.compare_ready++;
    end
    // Latency counted in cycles from the final transfer edge: COMPARE is cycle 1.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin
        o.latency = c + 1;
        break;
      end
    end
    if (o.latency < 0) return;
    o.pin   = best_pin;
    o.score = best_score;
    o.len   = best_len;
    o.pos   = best_pos;
    if (start_at_done) start = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    o.pulse_ok   = (done === 1'b0);
    o.hold_ok    = (best_pin === o.pin) && (best_score === o.score) &&
                   (best_len === o.len) && (best_pos === o.pos);
    o.busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_reduction = '0;
    in_weight    = '0;
    in_last      = 1'b0;
    in_pin       = '0;
    sweep_last   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    checks++; if (best_pin !== 9'd0) begin failures++; $display("FAIL reset_pin: got %0d expected 0", best_pin); end
    checks++; if (best_score !== 24'h800000) begin failures++; $display("FAIL reset_score: got %h expected 800000", best_score); end
    checks++; if (best_len !== 11'd0) begin failures++; $display("FAIL reset_len: got %0d expected 0", best_len); end
    checks++; if (best_pos !== 1'b0) begin failures++; $display("FAIL reset_pos: got %b expected 0", best_pos); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_line();
    obs_t o;
    sq.delete();
    add_line(5, 1'b1, 3, 150, 2);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.latency !== 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", o.latency); end
    checks++; if (o.pin !== 9'd5) begin failures++; $display("FAIL single_pin: got %0d expected 5", o.pin); end
    checks++; if (o.score !== 900) begin failures++; $display("FAIL single_score: got %0d expected 900", o.score); end
    checks++; if (o.len !== 11'd3) begin failures++; $display("FAIL single_len: got %0d expected 3", o.len); end
    checks++; if (o.pos !== 1'b1) begin failures++; $display("FAIL single_pos: got %b expected 1", o.pos); end
    checks++; if (!o.pulse_ok) begin failures++; $display("FAIL single_done_width: done still high after one cycle"); end
    checks++; if (!o.hold_ok) begin failures++; $display("FAIL single_hold: results changed after done"); end
    checks++; if (o.busy_after !== 1'b0) begin failures++; $display("FAIL single_idle: got busy %b expected 0", o.busy_after); end
  endtask

  task automatic test_tie();
    obs_t o;
    sq.delete();
    add_line(1, 1'b0, 1, 50, 2);
    add_line(2, 1'b0, 3, 100, 1);
    add_line(3, 1'b1, 1, 20, 15);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.latency !== 2) begin failures++; $display("FAIL tie_latency: got %0d expected 2", o.latency); end
    checks++; if (o.pin !== 9'd2) begin failures++; $display("FAIL tie_pin: got %0d expected 2", o.pin); end
    checks++; if (o.score !== 300) begin failures++; $display("FAIL tie_score: got %0d expected 300", o.score); end
    checks++; if (o.len !== 11'd3) begin failures++; $display("FAIL tie_len: got %0d expected 3", o.len); end
  endtask

  task automatic test_negative();
    obs_t o;
    sq.delete();
    add_line(7, 1'b0, 2, -20, 1);
    add_line(8, 1'b1, 1, -5, 2);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.pin !== 9'd8) begin failures++; $display("FAIL neg_pin: got %0d expected 8", o.pin); end
    checks++; if (o.score !== -10) begin failures++; $display("FAIL neg_score: got %0d expected -10", o.score); end
    checks++; if (o.len !== 11'd1) begin failures++; $display("FAIL neg_len: got %0d expected 1", o.len); end
    checks++; if (o.pos !== 1'b0) begin failures++; $display("FAIL neg_pos: got %b expected 0", o.pos); end
  endtask

  task automatic test_saturation();
    obs_t o;
    exp_t e;
    sq.delete();
    add_line(4, 1'b1, 1000, 32767, 15);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.score !== 8388607) begin failures++; $display("FAIL sat_pos_score: got %0d expected 8388607", o.score); end
    checks++; if (o.len !== 11'd1000) begin failures++; $display("FAIL sat_pos_len: got %0d expected 1000", o.len); end
    checks++; if (o.pos !== 1'b1) begin failures++; $display("FAIL sat_pos_flag: got %b expected 1", o.pos); end
    sq.delete();
    add_line(6, 1'b1, 1000, -32768, 15);
    e = model();
    run_sweep(-1, 1'b0, o);
    checks++; if (o.score !== -8388608) begin failures++; $display("FAIL sat_neg_score: got %0d expected -8388608", o.score); end
    checks++; if (o.pin !== e.pin) begin failures++; $display("FAIL sat_neg_pin: got %0d expected %0d", o.pin, e.pin); end
    checks++; if (o.pos !== 1'b0) begin failures++; $display("FAIL sat_neg_flag: got %b expected 0", o.pos); end
  endtask

  task automatic test_stall_and_start();
    obs_t o;
    exp_t e;
    sq.delete();
    add_line(10, 1'b0, 2, 7, 3);
    add_line(11, 1'b0, 2, -3, 9);
    add_line(12, 1'b1, 3, 5, 5);
    e = model();
    run_sweep(3, 1'b1, o);
    checks++; if (o.compare_ready !== 0) begin failures++; $display("FAIL stall_ready: got %0d ready cycles in compare expected 0", o.compare_ready); end
    checks++; if (o.latency !== 2) begin failures++; $display("FAIL stall_latency: got %0d expected 2", o.latency); end
    checks++; if (o.pin !== e.pin) begin failures++; $display("FAIL stall_pin: got %0d expected %0d", o.pin, e.pin); end
    checks++; if (o.score !== e.score) begin failures++; $display("FAIL stall_score: got %0d expected %0d", o.score, e.score); end
    checks++; if (o.len !== e.len) begin failures++; $display("FAIL stall_len: got %0d expected %0d", o.len, e.len); end
    checks++; if (o.busy_after !== 1'b0) begin failures++; $display("FAIL start_at_done: got busy %b expected 0", o.busy_after); end
  endtask

  task automatic test_reset_midline();
    obs_t  o;
    beat_t b;
    bit    ok;
    bit    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    b.red  = 16'd200;
    b.wt   = 4'd3;
    b.last = 1'b0;
    b.pin  = 9'd20;
    b.sl   = 1'b1;
    send_beat(b, ok);
    send_beat(b, ok);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_done: got done pulse expected none"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (best_pin !== 9'd0) begin failures++; $display("FAIL abort_pin: got %0d expected 0", best_pin); end
    checks++; if (best_score !== 24'h800000) begin failures++; $display("FAIL abort_score: got %h expected 800000", best_score); end
    checks++; if (best_len !== 11'd0) begin failures++; $display("FAIL abort_len: got %0d expected 0", best_len); end
    rst_n = 1'b1;
    sq.delete();
    add_line(3, 1'b1, 1, -75, 1);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.latency !== 2) begin failures++; $display("FAIL fresh_latency: got %0d expected 2", o.latency); end
    checks++; if (o.score !== -75) begin failures++; $display("FAIL fresh_score: got %0d expected -75", o.score); end
    checks++; if (o.len !== 11'd1) begin failures++; $display("FAIL fresh_len: got %0d expected 1", o.len); end
    checks++; if (o.pin !== 9'd3) begin failures++; $display("FAIL fresh_pin: got %0d expected 3", o.pin); end
  endtask

  task automatic test_len_saturation();
    obs_t o;
    sq.delete();
    add_line(9, 1'b1, 2100, int'($urandom_range(0, 65535)), 0);
    run_sweep(-1, 1'b0, o);
    checks++; if (o.score !== 0) begin failures++; $display("FAIL lensat_score: got %0d expected 0", o.score); end
    checks++; if (o.len !== 11'd2047) begin failures++; $display("FAIL lensat_len: got %0d expected 2047", o.len); end
    checks++; if (o.pos !== 1'b0) begin failures++; $display("FAIL lensat_pos: got %b expected 0", o.pos); end
  endtask

  task automatic test_random();
    obs_t  o;
    exp_t  e;
    beat_t b;
    int    nl;
    int    nb;
    for (int s = 0; s < 8; s++) begin
      sq.delete();
      nl = int'($urandom_range(1, 5));
      for (int l = 0; l < nl; l++) begin
        nb    = int'($urandom_range(1, 6));
        b.pin = 9'($urandom_range(0, 511));
        b.sl  = (l == nl - 1);
        for (int k = 0; k < nb; k++) begin
          b.red  = 16'($urandom);
          b.wt   = 4'($urandom_range(0, 15));
          b.last = (k == nb - 1);
          sq.push_back(b);
        end
      end
      e = model();
      run_sweep(-1, 1'b0, o);
      checks++; if (o.latency !== 2) begin failures++; $display("FAIL rand%0d_latency: got %0d expected 2", s, o.latency); end
      checks++; if (o.pin !== e.pin) begin failures++; $display("FAIL rand%0d_pin: got %0d expected %0d", s, o.pin, e.pin); end
      checks++; if (o.score !== e.score) begin failures++; $display("FAIL rand%0d_score: got %0d expected %0d", s, o.score, e.score); end
      checks++; if (o.len !== e.len) begin failures++; $display("FAIL rand%0d_len: got %0d expected %0d", s, o.len, e.len); end
      checks++; if (o.pos !== e.pos) begin failures++; $display("FAIL rand%0d_pos: got %b expected %b", s, o.pos, e.pos); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_line();
    test_tie();
    test_negative();
    test_saturation();
    test_stall_and_start();
    test_reset_midline();
    test_len_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
